// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
// Holds the FSM state encoding and the step-count helper for the parameter check.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Number of steps for a width/slice pair; 0 flags an illegal combination.
  function automatic int steps_f(input int width, input int bpc);
    if (bpc <= 0 || width < 1 || (width % bpc) != 0) begin
      return 0;
    end
    return width / bpc;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// master = requester side, slave = adder side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             iSTART;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iCIN;
  logic             iSUB;
  logic             oBUSY;
  logic             oDONE;
  logic [WIDTH-1:0] oSUM;
  logic             oCOUT;
  logic             oOVF;

  modport master (
    output iSTART, iA, iB, iCIN, iSUB,
    input  oBUSY, oDONE, oSUM, oCOUT, oOVF
  );

  modport slave (
    input  iSTART, iA, iB, iCIN, iSUB,
    output oBUSY, oDONE, oSUM, oCOUT, oOVF
  );
endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; chained to form each step's slice adder.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: BITS_PER_CYCLE bits per clock through a ripple chain of fa_cell.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         iCLK,
  input  logic         iRST_N,
  serial_adder_if.slave sa_bus
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (steps_f(WIDTH, BPC) == 0 || WIDTH < 2) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [BPC:0]       w_c;
  logic [BPC-1:0]     w_s;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_b_cap;
  logic               w_c_cap;

  assign w_c[0] = r_carry;

  for (genvar gi = 0; gi < BPC; gi++) begin : g_chain
    fa_cell u_fa (
      .i_a    (r_a[gi]),
      .i_b    (r_b[gi]),
      .i_cin  (w_c[gi]),
      .o_s    (w_s[gi]),
      .o_cout (w_c[gi+1])
    );
  end

  // Sum slices enter at the MSB end so the first slice ends up at bit 0.
  if (BPC == WIDTH) begin : g_acc_full
    assign w_acc_next = w_s;
  end else begin : g_acc_shift
    assign w_acc_next = {w_s, r_acc[WIDTH-1:BPC]};
  end

`ifdef SERIAL_ADDER_SUB_EN
  // A - B computed as A + ~B + 1.
  assign w_b_cap = sa_bus.iSUB ? ~sa_bus.iB : sa_bus.iB;
  assign w_c_cap = sa_bus.iSUB ? 1'b1 : sa_bus.iCIN;
`else
  assign w_b_cap = sa_bus.iB;
  assign w_c_cap = sa_bus.iCIN;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (sa_bus.iSTART) begin
            r_a     <= sa_bus.iA;
            r_b     <= w_b_cap;
            r_carry <= w_c_cap;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> BPC;
          r_b     <= r_b >> BPC;
          r_acc   <= w_acc_next;
          r_carry <= w_c[BPC];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(STEPS - 1)) begin
            // Overflow uses the carry into the top cell of the final slice.
            r_sum   <= w_acc_next;
            r_cout  <= w_c[BPC];
            r_ovf   <= w_c[BPC-1] ^ w_c[BPC];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sa_bus.oBUSY = r_busy;
  assign sa_bus.oDONE = r_done;
  assign sa_bus.oSUM  = r_sum;
  assign sa_bus.oCOUT = r_cout;
  assign sa_bus.oOVF  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table vectors through a scoreboard plus
// hand sequences for reset abort, continuous start, and a 4-bit-per-cycle instance.
module tb_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t sbq[$];
  int   done_cyc[$];
  exp_t mon_e;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(8)) bus4 ();

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .sa_bus (bus8)
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .sa_bus (bus4)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    logic [7:0] bb;
    logic       c;
    logic [8:0] s9;
    exp_t       r;
    bb = b;
    c  = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      bb = ~b;
      c  = 1'b1;
    end
`else
    if (sub) c = cin;
`endif
    s9     = {1'b0, a} + {1'b0, bb} + {8'd0, c};
    r.sum  = s9[7:0];
    r.cout = s9[8];
    r.ovf  = (a[7] == bb[7]) && (s9[7] != a[7]);
    return r;
  endfunction

  // Scoreboard side: every oDONE pulse pops one expectation.
  always @(negedge iCLK) begin
    if (iRST_N && bus8.oDONE) begin
      done_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got oDONE=1 sum=0x%0h, expected no completion", bus8.oSUM);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_sum", 32'(bus8.oSUM), 32'(mon_e.sum));
        chk("sb_cout", 32'(bus8.oCOUT), 32'(mon_e.cout));
        chk("sb_ovf", 32'(bus8.oOVF), 32'(mon_e.ovf));
        $display("[TB] done @%0d sum=0x%02h cout=%0d ovf=%0d", cyc, bus8.oSUM, bus8.oCOUT, bus8.oOVF);
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input exp_t e);
    int e_cyc;
    @(negedge iCLK);
    bus8.iA = a; bus8.iB = b; bus8.iCIN = cin; bus8.iSUB = sub; bus8.iSTART = 1'b1;
    sbq.push_back(e);
    done_cyc.delete();
    @(posedge iCLK); #1;
    e_cyc = cyc;
    bus8.iSTART = 1'b0;
    @(negedge iCLK);
    chk("busy_in_run", 32'(bus8.oBUSY), 32'd1);
    for (int k = 0; k < 20 && done_cyc.size() == 0; k++) begin
      @(negedge iCLK); #1;
    end
    if (done_cyc.size() == 0) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency", 32'(done_cyc[0] - e_cyc), 32'd8);
    end
    @(negedge iCLK);
    chk("done_pulse_1cyc", 32'(bus8.oDONE), 32'd0);
    chk("busy_after", 32'(bus8.oBUSY), 32'd0);
    chk("sum_held", 32'(bus8.oSUM), 32'(e.sum));
  endtask

  vec_t vecs[8];
  exp_t ee;
  int   e0;

  initial begin
    bus8.iSTART = 1'b0; bus8.iA = '0; bus8.iB = '0; bus8.iCIN = 1'b0; bus8.iSUB = 1'b0;
    bus4.iSTART = 1'b0; bus4.iA = '0; bus4.iB = '0; bus4.iCIN = 1'b0; bus4.iSUB = 1'b0;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
    vecs[6] = '{8'hC3, 8'hC3, 1'b0, 1'b0, 8'h86, 1'b1, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
    vecs[7] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
`else
    vecs[7] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0};
`endif

    repeat (3) @(negedge iCLK);
    chk("rst_sum", 32'(bus8.oSUM), 32'd0);
    chk("rst_flags", 32'({bus8.oBUSY, bus8.oDONE, bus8.oCOUT, bus8.oOVF}), 32'd0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    foreach (vecs[i]) begin
      $display("[TB] vec %0d: a=0x%02h b=0x%02h cin=%0d sub=%0d", i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             '{vecs[i].sum, vecs[i].cout, vecs[i].ovf});
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      $display("[TB] rnd %0d: a=0x%02h b=0x%02h cin=%0d sub=%0d", i, ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // Reset asserted four edges into a run: outputs clear, no completion follows.
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, '{8'h8D, 1'b0, 1'b1});
    @(negedge iCLK);
    bus8.iA = 8'h01; bus8.iB = 8'h02; bus8.iCIN = 1'b0; bus8.iSUB = 1'b0; bus8.iSTART = 1'b1;
    @(posedge iCLK); #1;
    bus8.iSTART = 1'b0;
    repeat (4) @(posedge iCLK);
    #1 iRST_N = 1'b0;
    #1;
    chk("abort_sum", 32'(bus8.oSUM), 32'd0);
    chk("abort_flags", 32'({bus8.oBUSY, bus8.oDONE, bus8.oCOUT, bus8.oOVF}), 32'd0);
    $display("[TB] reset abort at cycle %0d", cyc);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    done_cyc.delete();
    repeat (12) @(negedge iCLK);
    #1;
    chk("no_done_after_abort", 32'(done_cyc.size()), 32'd0);
    run_op(8'h21, 8'h43, 1'b1, 1'b0, '{8'h65, 1'b0, 1'b0});

    // iSTART held high: one result every 9 cycles; iA change mid-run ignored.
    @(negedge iCLK);
    bus8.iA = 8'h11; bus8.iB = 8'h22; bus8.iCIN = 1'b0; bus8.iSUB = 1'b0; bus8.iSTART = 1'b1;
    sbq.push_back('{8'h33, 1'b0, 1'b0});
    sbq.push_back('{8'h77, 1'b0, 1'b0});
    sbq.push_back('{8'h77, 1'b0, 1'b0});
    done_cyc.delete();
    @(posedge iCLK); #1;
    e0 = cyc;
    repeat (2) @(negedge iCLK);
    bus8.iA = 8'h55;
    for (int k = 0; k < 40 && cyc < e0 + 18; k++) begin
      @(posedge iCLK); #1;
    end
    bus8.iSTART = 1'b0;
    for (int k = 0; k < 40 && cyc < e0 + 30; k++) begin
      @(negedge iCLK); #1;
    end
    chk("cont_done_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      chk("cont_done0", 32'(done_cyc[0] - e0), 32'd8);
      chk("cont_done1", 32'(done_cyc[1] - e0), 32'd17);
      chk("cont_done2", 32'(done_cyc[2] - e0), 32'd26);
    end
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // Four bits per cycle: two steps.
    @(negedge iCLK);
    bus4.iA = 8'h7F; bus4.iB = 8'h01; bus4.iCIN = 1'b0; bus4.iSUB = 1'b0; bus4.iSTART = 1'b1;
    @(posedge iCLK); #1;
    e0 = cyc;
    bus4.iSTART = 1'b0;
    begin
      int k;
      for (k = 0; k < 20 && !bus4.oDONE; k++) begin
        @(negedge iCLK); #1;
      end
      if (!bus4.oDONE) begin
        chk("bpc4_timeout", 32'd0, 32'd1);
      end else begin
        chk("bpc4_latency", 32'(cyc - e0), 32'd2);
        chk("bpc4_sum", 32'(bus4.oSUM), 32'h80);
        chk("bpc4_cout", 32'(bus4.oCOUT), 32'd0);
        chk("bpc4_ovf", 32'(bus4.oOVF), 32'd1);
        $display("[TB] bpc4 done @%0d sum=0x%02h", cyc, bus4.oSUM);
      end
    end

    repeat (3) @(negedge iCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
